memgame_controller: RTL and testbench

- Game-logic stage directly upstream of the VGA card renderer in the memory card game.
- Conditions the raw buttons (select, move_x, move_y) and owns the cursor position.
- Owns the per-card state (hidden/revealed/matched) and the two-card compare/flip-back sequence.
- Outputs cursor_pos and card_state, which the renderer uses in place of its free-running pos register.

---
 rtl/memgame_pkg.sv | 31 +++
 rtl/memgame_controller_button_conditioner.sv | 45 ++++
 rtl/memgame_controller.sv | 156 +++++++++++++++
 tb/tb_memgame_controller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory card game (controller and renderer).
package memgame_pkg;

  localparam int unsigned NUM_CARDS = 20;
  localparam int unsigned NUM_ROWS  = 4;
  localparam int unsigned NUM_COLS  = 5;
  localparam int unsigned NUM_PAIRS = 10;

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    REVEALED = 2'd1,
    MATCHED  = 2'd2
  } card_state_t;

  typedef enum logic [1:0] {
    PICK1,
    PICK2,
    SHOW,
    WIN
  } fsm_t;

  // Pair id of deal entry idx; entries are 5 bits wide, two cards share each id.
  function automatic logic [3:0] pair_id(input logic [99:0] order, input logic [4:0] idx);
    logic [6:0] base;
    logic [4:0] entry;
    base  = 7'(idx) * 7'd5;
    entry = order[base +: 5];
    return entry[4:1];
  endfunction

endpackage

// File: rtl/memgame_controller_button_conditioner.sv
// Raw button -> 2-flop synchroniser -> debounce -> one-clock rising-edge pulse.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clock_50M,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_prev_q, pulse_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock_50M or posedge reset) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      pulse_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      // Accept a new level only after it has differed for DEBOUNCE_CYCLES clocks in a row.
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      stable_prev_q <= stable_q;
      pulse_q       <= stable_q & ~stable_prev_q;
    end
  end

  assign btn_pulse = pulse_q;

endmodule

// File: rtl/memgame_controller.sv
// Memory game logic: cursor, per-card state and pick/compare/flip-back FSM.
// Define MEMGAME_ATTEMPT_COUNT_EN to enable the saturating attempts counter.
module memgame_controller
  import memgame_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned SHOW_CYCLES     = 50_000_000
) (
  input  logic         clock_50M,
  input  logic         reset,
  input  logic         select,
  input  logic         move_x,
  input  logic         move_y,
  input  logic [99:0]  card_order,
  output logic [4:0]   cursor_pos,
  output logic [39:0]  card_state,
  output logic [3:0]   pairs_found,
  output logic         busy,
  output logic         game_over,
  output logic [7:0]   attempts
);

  localparam int unsigned ShowW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  logic sel_p, mx_p, my_p;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clock_50M(clock_50M), .reset(reset), .btn_raw(select), .btn_pulse(sel_p)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mx (
    .clock_50M(clock_50M), .reset(reset), .btn_raw(move_x), .btn_pulse(mx_p)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_my (
    .clock_50M(clock_50M), .reset(reset), .btn_raw(move_y), .btn_pulse(my_p)
  );

  fsm_t                       fsm_q;
  logic [4:0]                 cursor_q, cursor_d, first_q, second_q;
  logic [2*NUM_CARDS-1:0]     cards_q;
  logic [3:0]                 pairs_q;
  logic                       busy_q, game_over_q;
  logic [ShowW-1:0]           show_cnt_q;

  logic [5:0] cur_base, first_base, second_base;
  logic [1:0] cur_card;
  logic       pick2_sel, redeal, pair_match;

  assign cur_base    = {cursor_q, 1'b0};
  assign first_base  = {first_q, 1'b0};
  assign second_base = {second_q, 1'b0};
  assign cur_card    = cards_q[cur_base +: 2];
  assign pick2_sel   = (fsm_q == PICK2) && sel_p && (cur_card == HIDDEN);
  assign redeal      = (fsm_q == WIN) && sel_p;
  assign pair_match  = pair_id(card_order, first_q) == pair_id(card_order, cursor_q);

  // move_x takes priority; rows wrap within a column, columns wrap across the board.
  always_comb begin
    cursor_d = cursor_q;
    if (mx_p) begin
      cursor_d = (cursor_q < 5'(NUM_ROWS)) ? cursor_q + 5'(NUM_ROWS * (NUM_COLS - 1))
                                           : cursor_q - 5'(NUM_ROWS);
    end else if (my_p) begin
      cursor_d = (cursor_q[1:0] == 2'(NUM_ROWS - 1)) ? cursor_q - 5'(NUM_ROWS - 1)
                                                     : cursor_q + 5'd1;
    end
  end

  always_ff @(posedge clock_50M or posedge reset) begin
    if (reset) begin
      fsm_q       <= PICK1;
      cursor_q    <= '0;
      first_q     <= '0;
      second_q    <= '0;
      cards_q     <= '0;
      pairs_q     <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      show_cnt_q  <= '0;
    end else begin
      cursor_q <= redeal ? 5'd0 : cursor_d;
      case (fsm_q)
        PICK1: begin
          if (sel_p && cur_card == HIDDEN) begin
            cards_q[cur_base +: 2] <= REVEALED;
            first_q                <= cursor_q;
            fsm_q                  <= PICK2;
          end
        end
        PICK2: begin
          if (pick2_sel) begin
            second_q <= cursor_q;
            if (pair_match) begin
              cards_q[first_base +: 2] <= MATCHED;
              cards_q[cur_base +: 2]   <= MATCHED;
              pairs_q                  <= pairs_q + 4'd1;
              if (pairs_q == 4'(NUM_PAIRS - 1)) begin
                fsm_q       <= WIN;
                game_over_q <= 1'b1;
              end else begin
                fsm_q <= PICK1;
              end
            end else begin
              cards_q[cur_base +: 2] <= REVEALED;
              show_cnt_q             <= ShowW'(SHOW_CYCLES - 1);
              busy_q                 <= 1'b1;
              fsm_q                  <= SHOW;
            end
          end
        end
        SHOW: begin
          if (show_cnt_q == '0) begin
            cards_q[first_base +: 2]  <= HIDDEN;
            cards_q[second_base +: 2] <= HIDDEN;
            busy_q                    <= 1'b0;
            fsm_q                     <= PICK1;
          end else begin
            show_cnt_q <= show_cnt_q - 1'b1;
          end
        end
        WIN: begin
          if (sel_p) begin
            cards_q     <= '0;
            pairs_q     <= '0;
            game_over_q <= 1'b0;
            fsm_q       <= PICK1;
          end
        end
      endcase
    end
  end

`ifdef MEMGAME_ATTEMPT_COUNT_EN
  logic [7:0] attempts_q;

  always_ff @(posedge clock_50M or posedge reset) begin
    if (reset) begin
      attempts_q <= '0;
    end else if (redeal) begin
      attempts_q <= '0;
    end else if (pick2_sel && attempts_q != 8'hFF) begin
      attempts_q <= attempts_q + 8'd1;
    end
  end

  assign attempts = attempts_q;
`else
  assign attempts = 8'd0;
`endif

  assign cursor_pos  = cursor_q;
  assign card_state  = cards_q;
  assign pairs_found = pairs_q;
  assign busy        = busy_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_memgame_controller.sv
// Scoreboard bench for memgame_controller: a model pushes expected output snapshots,
// a monitor pops one per observed output change.
module tb_memgame_controller;
  import memgame_pkg::*;

  localparam int unsigned Deb   = 4;
  localparam int unsigned Show  = 10;
  localparam int unsigned Show2 = 40;
`ifdef MEMGAME_ATTEMPT_COUNT_EN
  localparam int AttOn = 1;
`else
  localparam int AttOn = 0;
`endif

  typedef struct packed {
    logic [4:0]  cur;
    logic [39:0] cards;
    logic [3:0]  pairs;
    logic        busy;
    logic        go;
    logic [7:0]  att;
  } snap_t;

  logic clk = 1'b0, rst = 1'b1;
  logic sel_raw = 1'b0, mx_raw = 1'b0, my_raw = 1'b0, sel2_raw = 1'b0;
  logic [99:0] order;
  logic [4:0]  cursor_pos, cursor_pos2;
  logic [39:0] card_state, card_state2;
  logic [3:0]  pairs_found, pairs_found2;
  logic        busy, busy2, game_over, game_over2;
  logic [7:0]  attempts, attempts2;

  int tbl [20] = '{7, 4, 16, 6, 18, 19, 5, 17, 2, 0, 10, 9, 12, 8, 11, 3, 1, 13, 15, 14};
  int pa  [10] = '{0, 1, 2, 4, 8, 9, 10, 11, 12, 18};
  int pb  [10] = '{3, 6, 7, 5, 15, 16, 14, 13, 17, 19};

  always #5 clk = ~clk;

  memgame_controller #(.DEBOUNCE_CYCLES(Deb), .SHOW_CYCLES(Show)) dut (
    .clock_50M(clk), .reset(rst), .select(sel_raw), .move_x(mx_raw), .move_y(my_raw),
    .card_order(order), .cursor_pos(cursor_pos), .card_state(card_state),
    .pairs_found(pairs_found), .busy(busy), .game_over(game_over), .attempts(attempts)
  );

  // Longer SHOW so a select can be landed inside the SHOW window.
  memgame_controller #(.DEBOUNCE_CYCLES(Deb), .SHOW_CYCLES(Show2)) dut2 (
    .clock_50M(clk), .reset(rst), .select(sel2_raw), .move_x(mx_raw), .move_y(my_raw),
    .card_order(order), .cursor_pos(cursor_pos2), .card_state(card_state2),
    .pairs_found(pairs_found2), .busy(busy2), .game_over(game_over2), .attempts(attempts2)
  );

  int    n_tests = 0, n_fail = 0;
  snap_t exp_q[$];
  snap_t prev_s;
  bit    mon_en = 1'b0;

  // Model state: st 0=PICK1 1=PICK2 2=SHOW 3=WIN
  int         m_cur, m_pairs, m_att, m_st, m_first;
  logic       m_busy, m_go;
  logic [1:0] m_cards [20];

  function automatic string fmt(input snap_t s);
    return $sformatf("cur=%0d cards=%h pairs=%0d busy=%0b go=%0b att=%0d",
                     s.cur, s.cards, s.pairs, s.busy, s.go, s.att);
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.cur = cursor_pos; s.cards = card_state; s.pairs = pairs_found;
    s.busy = busy; s.go = game_over; s.att = attempts;
    return s;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.cur = 5'(m_cur);
    for (int k = 0; k < 20; k++) s.cards[2*k +: 2] = m_cards[k];
    s.pairs = 4'(m_pairs); s.busy = m_busy; s.go = m_go; s.att = 8'(m_att);
    return s;
  endfunction

  function automatic int pid(input int k);
    return tbl[k] >> 1;
  endfunction

  task automatic model_reset();
    m_cur = 0; m_pairs = 0; m_att = 0; m_st = 0; m_first = 0;
    m_busy = 1'b0; m_go = 1'b0;
    for (int k = 0; k < 20; k++) m_cards[k] = 2'd0;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    snap_t cur_s, e;
    if (mon_en) begin
      cur_s = dut_snap();
      if (cur_s !== prev_s) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change got %s", fmt(cur_s));
        end else begin
          e = exp_q.pop_front();
          if (cur_s !== e) begin
            n_fail++;
            $display("FAIL output_change got %s expected %s", fmt(cur_s), fmt(e));
          end
        end
        prev_s = cur_s;
      end
    end
  end

  int busy_run = 0, last_busy_len = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) busy_run++;
    else begin
      if (busy_run != 0) last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic reset_dut(input bit chk);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    if (chk) begin
      check("rst_cursor", 64'(cursor_pos), 64'd0);
      check("rst_cards", 64'(card_state), 64'd0);
      check("rst_pairs", 64'(pairs_found), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_game_over", 64'(game_over), 64'd0);
      check("rst_attempts", 64'(attempts), 64'd0);
    end
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    prev_s = dut_snap();
    mon_en = 1'b1;
  endtask

  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: sel_raw = 1'b1;
      1: mx_raw = 1'b1;
      2: my_raw = 1'b1;
      default: sel2_raw = 1'b1;
    endcase
    repeat (8) @(negedge clk);
    sel_raw = 1'b0; mx_raw = 1'b0; my_raw = 1'b0; sel2_raw = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_level(input bit second, input logic lvl, input string name);
    int n;
    n = 0;
    while (((second ? busy2 : busy) !== lvl) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout waiting for busy=%0b", name, lvl);
    end
  endtask

  task automatic do_my();
    m_cur = ((m_cur + 1) % 4 == 0) ? m_cur - 3 : m_cur + 1;
    exp_q.push_back(model_snap());
    press(2);
  endtask

  task automatic do_mx();
    m_cur = (m_cur < 4) ? m_cur + 16 : m_cur - 4;
    exp_q.push_back(model_snap());
    press(1);
  endtask

  // Updates the model for one select pulse; returns 1 if it starts a SHOW.
  task automatic model_sel(output bit mismatch);
    mismatch = 1'b0;
    if (m_st == 3) begin
      for (int k = 0; k < 20; k++) m_cards[k] = 2'd0;
      m_pairs = 0; m_att = 0; m_cur = 0; m_go = 1'b0; m_st = 0;
      exp_q.push_back(model_snap());
    end else if (m_st == 2 || m_cards[m_cur] != 2'd0) begin
      // ignored
    end else if (m_st == 0) begin
      m_cards[m_cur] = 2'd1; m_first = m_cur; m_st = 1;
      exp_q.push_back(model_snap());
    end else begin
      if (AttOn != 0 && m_att < 255) m_att++;
      if (pid(m_first) == pid(m_cur)) begin
        m_cards[m_first] = 2'd2; m_cards[m_cur] = 2'd2; m_pairs++;
        if (m_pairs == 10) begin m_st = 3; m_go = 1'b1; end else m_st = 0;
        exp_q.push_back(model_snap());
      end else begin
        mismatch = 1'b1;
        m_cards[m_cur] = 2'd1; m_busy = 1'b1;
        exp_q.push_back(model_snap());
        m_cards[m_cur] = 2'd0; m_cards[m_first] = 2'd0; m_busy = 1'b0; m_st = 0;
        exp_q.push_back(model_snap());
      end
    end
  endtask

  task automatic do_sel();
    bit mm;
    model_sel(mm);
    press(0);
    if (mm) wait_level(1'b0, 1'b0, "show_end");
  endtask

  task automatic goto_pos(input int p);
    while (m_cur / 4 != p / 4) do_mx();
    while (m_cur % 4 != p % 4) do_my();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mm;
    for (int k = 0; k < 20; k++) order[5*k +: 5] = 5'(tbl[k]);
    model_reset();
    reset_dut(1'b1);

    // Cursor wrap within a column and across columns
    repeat (4) do_my();
    do_mx();
    do_mx();
    check("cursor_wrap", 64'(cursor_pos), 64'd12);
    goto_pos(0);

    // Mismatch with a reselect of a REVEALED card in between
    do_sel();
    do_sel();
    check("reselect_revealed_cards", 64'(card_state), 64'h1);
    check("reselect_revealed_att", 64'(attempts), 64'd0);
    do_my();
    do_sel();
    @(negedge clk);
    check("show_busy_len", 64'(last_busy_len), 64'd10);
    check("show_flip_back", 64'(card_state), 64'd0);

    // 2-clock glitch on select at a hidden card
    @(negedge clk) sel_raw = 1'b1;
    @(negedge clk);
    @(negedge clk) sel_raw = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_no_pulse", 64'(card_state), 64'd0);

    // Match of cards 0 and 3 (pair 3), then reselect a MATCHED card
    goto_pos(0);
    do_sel();
    goto_pos(3);
    do_sel();
    check("match_cards", 64'(card_state), 64'h82);
    check("match_pairs", 64'(pairs_found), 64'd1);
    goto_pos(0);
    do_sel();
    check("reselect_matched_cards", 64'(card_state), 64'h82);
    check("reselect_matched_att", 64'(attempts), 64'(2 * AttOn));

    // Win, then re-deal
    for (int i = 0; i < 10; i++) begin
      if (m_cards[pa[i]] == 2'd2) continue;
      goto_pos(pa[i]);
      do_sel();
      goto_pos(pb[i]);
      do_sel();
    end
    check("win_game_over", 64'(game_over), 64'd1);
    check("win_pairs", 64'(pairs_found), 64'd10);
    check("win_cards", 64'(card_state), 64'hAA_AAAA_AAAA);
    do_sel();
    check("redeal_cards", 64'(card_state), 64'd0);
    check("redeal_pairs", 64'(pairs_found), 64'd0);
    check("redeal_cursor", 64'(cursor_pos), 64'd0);
    check("redeal_game_over", 64'(game_over), 64'd0);

    // Asynchronous reset in the middle of SHOW
    do_sel();
    do_my();
    model_sel(mm);
    @(negedge clk) sel_raw = 1'b1;
    wait_level(1'b0, 1'b1, "show_start");
    repeat (3) @(negedge clk);
    sel_raw = 1'b0;
    reset_dut(1'b1);
    repeat (10) @(negedge clk);

    // Select during SHOW is ignored (long-SHOW instance)
    press(3);
    do_my();
    press(3);
    press(3);
    check("show_sel_busy", 64'(busy2), 64'd1);
    check("show_sel_cards", 64'(card_state2), 64'h5);
    wait_level(1'b1, 1'b0, "show2_end");
    check("show_sel_flip_back", 64'(card_state2), 64'd0);

`ifdef MEMGAME_ATTEMPT_COUNT_EN
    // Saturation: cycle columns 0,16,12,8,4 where neighbours never share a pair id
    goto_pos(0);
    for (int i = 0; i < 300; i++) begin
      do_sel();
      do_mx();
      do_sel();
    end
    check("attempts_saturate", 64'(attempts), 64'd255);
`else
    check("attempts_tied_off", 64'(attempts), 64'd0);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
